// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bus between the hazard/EX/imem side and the PC sequencer.
interface pc_sequencer_if #(parameter int WIDTH = 16);
  logic stall;
  logic imem_ready;
  logic redirect;
  logic [WIDTH-1:0] redirect_target;
  logic halt_detect;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus2;
  logic flush_if;
  logic halted;
  logic halt_done;
  modport master(
    output stall, imem_ready, redirect, redirect_target, halt_detect,
    input pc, pc_plus2, flush_if, halted, halt_done
  );
  modport slave(
    input stall, imem_ready, redirect, redirect_target, halt_detect,
    output pc, pc_plus2, flush_if, halted, halt_done
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC owner arbitrating advance, stall, imem wait, redirect and halt.
module pc_sequencer #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int INC = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  pc_sequencer_if.slave bus
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, MISS, MISS_REDIR, HALTED} state_t;
  state_t state;
  logic [WIDTH-1:0] target;
  logic [CW-1:0] cnt;
  assign bus.pc_plus2 = bus.pc + WIDTH'(INC);
  assign bus.flush_if = bus.redirect || state == MISS_REDIR;
  // Sequencer FSM: redirect beats imem wait beats halt beats stall beats advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      bus.pc <= RESET_PC;
      target <= '0;
      cnt <= '0;
      bus.halted <= 1'b0;
      bus.halt_done <= 1'b0;
    end else begin
      case (state)
        RUN, MISS: begin
          if (bus.redirect && (state == MISS || !bus.imem_ready)) begin
            target <= bus.redirect_target;
            state <= MISS_REDIR;
          end else if (bus.redirect) begin
            bus.pc <= bus.redirect_target;
          end else if (!bus.imem_ready) begin
            state <= MISS;
          end else if (bus.halt_detect) begin
            state <= HALTED;
            cnt <= '0;
            bus.halted <= 1'b1;
          end else begin
            state <= RUN;
            if (!bus.stall) bus.pc <= bus.pc_plus2;
          end
        end
        MISS_REDIR: begin
          if (bus.redirect) target <= bus.redirect_target;
          if (bus.imem_ready) begin
            bus.pc <= bus.redirect ? bus.redirect_target : target;
            state <= RUN;
          end
        end
        HALTED: begin
          if (bus.redirect) begin
            bus.pc <= bus.redirect_target;
            state <= RUN;
            cnt <= '0;
            bus.halted <= 1'b0;
            bus.halt_done <= 1'b0;
          end else begin
            if (cnt != CW'(DRAIN_CYCLES)) cnt <= cnt + CW'(1);
            bus.halt_done <= cnt >= CW'(DRAIN_CYCLES - 1);
          end
        end
      endcase
    end
  end
endmodule
